// File: rtl/push_control_array_pkg.sv
// -----------------------------------------------------------------------------
// push_control_array_pkg
// Shared definitions for the push-button conditioning array: per-channel
// state encoding and default timing constants for a 50 MHz system clock.
// No ports.
// -----------------------------------------------------------------------------
package push_control_array_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_DB_CNT   = 100000;    // 2 ms at 50 MHz
  localparam int DEF_HOLD_CNT = 25000000;  // 0.5 s at 50 MHz

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_HELD         = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/push_control_array_channel.sv
// -----------------------------------------------------------------------------
// push_channel
// One button channel: 2-FF synchroniser, debounce counter, press/release
// one-shots and long-press (hold) detection. All outputs are registered.
//
// State table:
//   ST_IDLE         | accepted level released, waiting for a press
//   ST_PRESS_WAIT   | press seen, counting stable cycles before accepting
//   ST_PRESSED      | press accepted, counting toward hold
//   ST_HELD         | press lasted HOLD_CNT cycles, o_Hold asserted
//   ST_RELEASE_WAIT | release seen, counting stable cycles before accepting
//
// Ports:
//   i_Clk      system clock
//   i_Rst      asynchronous active-low reset
//   i_Push     raw asynchronous button level
//   o_fPush    one-cycle pulse on accepted press
//   o_fRelease one-cycle pulse on accepted release
//   o_Level    debounced pressed level
//   o_Hold     high while the press has lasted >= HOLD_CNT cycles
//   o_fHold    one-cycle pulse when o_Hold rises
// -----------------------------------------------------------------------------
module push_channel
  import push_control_array_pkg::*;
#(
  parameter int DB_CNT     = DEF_DB_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int IN_ACT_LOW = 0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Push,
  output logic o_fPush,
  output logic o_fRelease,
  output logic o_Level,
  output logic o_Hold,
  output logic o_fHold
);

  localparam int DBW = $clog2(DB_CNT + 1);
  localparam int HW  = $clog2(HOLD_CNT + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [DBW-1:0] DB_ZERO   = '0;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
  localparam logic           ACT_FLIP  = (IN_ACT_LOW != 0);

  logic           r_sync1, r_sync2;
  state_t         r_state;
  logic [DBW-1:0] r_db;
  logic [HW-1:0]  r_hold_cnt;
  logic           r_level, r_hold, r_fpush, r_frel, r_fhold;

  state_t         w_state_nxt;
  logic [DBW-1:0] w_db_nxt;
  logic [HW-1:0]  w_hold_cnt_nxt;
  logic           w_level_nxt, w_hold_nxt, w_fpush_nxt, w_frel_nxt, w_fhold_nxt;
  logic           w_s;

  // Polarity is folded in ahead of the first flop so that the reset value of
  // both stages means "not pressed" regardless of IN_ACT_LOW.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Push ^ ACT_FLIP;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state    <= ST_IDLE;
      r_db       <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_hold     <= 1'b0;
      r_fpush    <= 1'b0;
      r_frel     <= 1'b0;
      r_fhold    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db       <= w_db_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_level    <= w_level_nxt;
      r_hold     <= w_hold_nxt;
      r_fpush    <= w_fpush_nxt;
      r_frel     <= w_frel_nxt;
      r_fhold    <= w_fhold_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_db_nxt       = r_db;
    w_hold_cnt_nxt = r_hold_cnt;
    w_level_nxt    = r_level;
    w_hold_nxt     = r_hold;
    w_fpush_nxt    = 1'b0;
    w_frel_nxt     = 1'b0;
    w_fhold_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_db_nxt    = DB_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = DB_ZERO;
        end else if (r_db == DB_LAST) begin
          w_state_nxt    = ST_PRESSED;
          w_db_nxt       = DB_ZERO;
          w_level_nxt    = 1'b1;
          w_fpush_nxt    = 1'b1;
          w_hold_cnt_nxt = '0;
        end else begin
          w_db_nxt = r_db + DB_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_db_nxt    = DB_ONE;
        end else begin
          // Ends at HOLD_CNT and stays there: HELD never touches the counter.
          w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = ST_HELD;
            w_hold_nxt  = 1'b1;
            w_fhold_nxt = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_db_nxt    = DB_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s) begin
          // r_hold still marks whether the bounce started from HELD.
          w_state_nxt = r_hold ? ST_HELD : ST_PRESSED;
          w_db_nxt    = DB_ZERO;
        end else if (r_db == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = DB_ZERO;
          w_level_nxt = 1'b0;
          w_hold_nxt  = 1'b0;
          w_frel_nxt  = 1'b1;
        end else begin
          w_db_nxt = r_db + DB_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_db_nxt    = DB_ZERO;
      end
    endcase
  end

  assign o_fPush    = r_fpush;
  assign o_fRelease = r_frel;
  assign o_Level    = r_level;
  assign o_Hold     = r_hold;
  assign o_fHold    = r_fhold;

endmodule

// File: rtl/push_control_array.sv
// -----------------------------------------------------------------------------
// push_control_array
// N_CH independent push-button conditioning channels. o_fPush is the one-shot
// press output used by the rhythm-game judge logic.
//
// Ports (all vectors are N_CH wide, bit k = channel k):
//   i_Clk      system clock
//   i_Rst      asynchronous active-low reset
//   i_Push     raw asynchronous button inputs
//   o_fPush    one-cycle pulse on accepted press
//   o_fRelease one-cycle pulse on accepted release
//   o_Level    debounced pressed level
//   o_Hold     high while a press has lasted >= HOLD_CNT cycles
//   o_fHold    one-cycle pulse when o_Hold rises
// -----------------------------------------------------------------------------
module push_control_array
  import push_control_array_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DB_CNT     = DEF_DB_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int IN_ACT_LOW = 0
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic [N_CH-1:0] i_Push,
  output logic [N_CH-1:0] o_fPush,
  output logic [N_CH-1:0] o_fRelease,
  output logic [N_CH-1:0] o_Level,
  output logic [N_CH-1:0] o_Hold,
  output logic [N_CH-1:0] o_fHold
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    push_channel #(
      .DB_CNT    (DB_CNT),
      .HOLD_CNT  (HOLD_CNT),
      .IN_ACT_LOW(IN_ACT_LOW)
    ) u_ch (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Push    (i_Push[k]),
      .o_fPush   (o_fPush[k]),
      .o_fRelease(o_fRelease[k]),
      .o_Level   (o_Level[k]),
      .o_Hold    (o_Hold[k]),
      .o_fHold   (o_fHold[k])
    );
  end

endmodule

// File: tb/tb_push_control_array.sv
// -----------------------------------------------------------------------------
// tb_push_control_array
// Directed bench for push_control_array (N_CH=4, DB_CNT=4, HOLD_CNT=10).
// A run-length reference model predicts every output each cycle; directed
// sequences pin pulse latencies with hand-computed cycle counts.
// -----------------------------------------------------------------------------
module tb_push_control_array;

  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] push = '1;
  logic [N-1:0] o_fPush, o_fRelease, o_Level, o_Hold, o_fHold;

  int tests = 0;
  int fails = 0;

  push_control_array #(
    .N_CH(N), .DB_CNT(DB), .HOLD_CNT(HOLD), .IN_ACT_LOW(0)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst_n),
    .i_Push    (push),
    .o_fPush   (o_fPush),
    .o_fRelease(o_fRelease),
    .o_Level   (o_Level),
    .o_Hold    (o_Hold),
    .o_fHold   (o_fHold)
  );

  initial forever #5 clk = ~clk;

  // Reference model: a channel accepts a new level once the synchronised input
  // has disagreed with the accepted level for DB consecutive cycles. Any cycle
  // of agreement after a disagreement only cancels the pending change. Hold
  // time accumulates over cycles where a press is accepted and nothing is
  // pending.
  logic [N-1:0] m_d1 = '0, m_d2 = '0, m_s;
  logic [N-1:0] m_acc = '0, e_hold = '0, e_fpush = '0, e_frel = '0, e_fhold = '0;
  int           m_run [N];
  int           m_hcnt[N];

  initial begin
    for (int k = 0; k < N; k++) begin
      m_run[k]  = 0;
      m_hcnt[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_d1 = '0; m_d2 = '0; m_acc = '0; e_hold = '0;
        e_fpush = '0; e_frel = '0; e_fhold = '0;
        for (int k = 0; k < N; k++) begin
          m_run[k]  = 0;
          m_hcnt[k] = 0;
        end
      end else begin
        m_s = m_d2;
        e_fpush = '0; e_frel = '0; e_fhold = '0;
        for (int k = 0; k < N; k++) begin
          if (m_s[k] != m_acc[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_run[k] = 0;
              m_acc[k] = m_s[k];
              if (m_s[k]) begin
                e_fpush[k] = 1'b1;
                m_hcnt[k]  = 0;
              end else begin
                e_frel[k] = 1'b1;
                e_hold[k] = 1'b0;
              end
            end
          end else if (m_run[k] != 0) begin
            m_run[k] = 0;
          end else if (m_acc[k] && m_hcnt[k] < HOLD) begin
            m_hcnt[k]++;
            if (m_hcnt[k] == HOLD) begin
              e_hold[k]  = 1'b1;
              e_fhold[k] = 1'b1;
            end
          end
        end
        m_d2 = m_d1;
        m_d1 = push;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    tests++;
    if ({o_fPush, o_fRelease, o_Level, o_Hold, o_fHold} !==
        {e_fpush, e_frel, m_acc, e_hold, e_fhold}) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t got fP=%h fR=%h L=%h H=%h fH=%h exp fP=%h fR=%h L=%h H=%h fH=%h",
               $time, o_fPush, o_fRelease, o_Level, o_Hold, o_fHold,
               e_fpush, e_frel, m_acc, e_hold, e_fhold);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts negedges until the selected pulse shows on channel ch; -1 if the
  // budget runs out. sel: 0 = o_fPush, 1 = o_fRelease, 2 = o_fHold.
  task automatic wait_sig(input int sel, input int ch, input int limit, output int n);
    logic [N-1:0] v;
    bit           hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       v = o_fPush;
        1:       v = o_fRelease;
        default: v = o_fHold;
      endcase
      if (v[ch]) hit = 1'b1;
    end
    if (!hit) n = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1. Reset with all buttons pressed, then release reset.
    tick(3);
    check("rst_level", int'(o_Level), 0);
    check("rst_pulses", int'({o_fPush, o_fRelease, o_fHold, o_Hold}), 0);
    rst_n = 1'b1;
    wait_sig(0, 0, 10, n);
    check("t1_fpush_lat", n, 6);
    check("t1_fpush_all", int'(o_fPush), 15);
    check("t1_level_all", int'(o_Level), 15);
    check("t1_model_level", int'(m_acc), 15);
    push = '0;
    wait_sig(1, 0, 10, n);
    check("t1_frel_lat", n, 6);
    check("t1_frel_all", int'(o_fRelease), 15);
    check("t1_level_off", int'(o_Level), 0);
    tick(4);

    // 2. Glitch rejection, then a minimal accepted press on channel 0.
    push = 4'b0001;
    tick(3);
    push = 4'b0000;
    wait_sig(0, 0, 8, n);
    check("t2_glitch_nopush", n, -1);
    check("t2_glitch_level", int'(o_Level[0]), 0);
    push = 4'b0001;
    tick(4);
    push = 4'b0000;
    wait_sig(0, 0, 6, n);
    check("t2_fpush_lat", n + 4, 6);
    check("t2_model_fpush", int'(e_fpush), 1);
    wait_sig(1, 0, 8, n);
    check("t2_frel_lat", n, 4);
    tick(4);

    // 3. Long press on channel 1.
    push = 4'b0010;
    wait_sig(0, 1, 10, n);
    check("t3_fpush_lat", n, 6);
    wait_sig(2, 1, 15, n);
    check("t3_fhold_lat", n, 10);
    check("t3_hold_on", int'(o_Hold[1]), 1);
    tick(3);
    check("t3_hold_stays", int'(o_Hold[1]), 1);
    push = 4'b0000;
    wait_sig(1, 1, 10, n);
    check("t3_frel_lat", n, 6);
    check("t3_hold_off", int'(o_Hold[1]), 0);
    tick(4);

    // 4. Release bounce on channel 2: three hold-count cycles are lost.
    push = 4'b0100;
    wait_sig(0, 2, 10, n);
    check("t4_fpush_lat", n, 6);
    tick(2);
    push = 4'b0000;
    tick(2);
    push = 4'b0100;
    wait_sig(2, 2, 15, n);
    check("t4_fhold_lat", n, 9);
    check("t4_level_kept", int'(o_Level[2]), 1);
    push = 4'b0000;
    wait_sig(1, 2, 10, n);
    check("t4_frel_lat", n, 6);
    tick(4);

    // 5. Staggered presses on channels 0 and 3.
    push = 4'b0001;
    tick(1);
    push = 4'b1001;
    wait_sig(0, 0, 10, n);
    check("t5_ch0_lat", n, 5);
    check("t5_ch0_only", int'(o_fPush), 1);
    tick(1);
    check("t5_ch3_only", int'(o_fPush), 8);
    push = 4'b0000;
    tick(10);

    // 6. Reset while channel 1 is held.
    push = 4'b0010;
    wait_sig(0, 1, 10, n);
    check("t6_fpush_lat", n, 6);
    wait_sig(2, 1, 15, n);
    check("t6_fhold_lat", n, 10);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_hold_async", int'(o_Hold[1]), 0);
    check("t6_level_async", int'(o_Level[1]), 0);
    check("t6_no_frel", int'(o_fRelease), 0);
    push = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    wait_sig(1, 1, 12, n);
    check("t6_no_frel_after", n, -1);
    check("t6_level_after", int'(o_Level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
